dht_sensor_responder: RTL and testbench

Synthesizable single-wire responder that emulates a DHT11-class temperature/humidity sensor. It answers a host start pulse with the 80 µs response preamble and a 40-bit frame built from humidity and temperature register inputs. It sits on the far end of the same bus that the project's sensor reader drives, so the reader can be exercised in loopback on the board and in simulation without a physical sensor.

---
 rtl/dht_sensor_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_dht_sensor_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_sensor_responder.sv
// ----------------------------------------------------------------------------
// dht_sensor_responder
//
// Emulates a DHT11-class single-wire temperature/humidity sensor. A host start
// pulse (bus held low for at least START_MIN_US) is answered with an 80 us
// low / 80 us high preamble followed by a 40-bit frame:
//   humid_int, humid_dec, temp_int, temp_dec, checksum  (MSB first per byte)
// Each bit is a 50 us low followed by a 26 us (bit 0) or 70 us (bit 1) release.
// The frame closes with a 50 us low, after which the bus is released.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-low reset
//   i_bus          raw single-wire level (external pull-up, asynchronous)
//   o_bus_oe       1 = pull bus low, 0 = release
//   i_humid_int    payload byte 0
//   i_humid_dec    payload byte 1
//   i_temp_int     payload byte 2
//   i_temp_dec     payload byte 3
//   i_csum_err     (DHT_CSUM_ERR_INJ_EN only) invert the transmitted checksum
//   o_busy         high from start acceptance until the end of the frame
//   o_frame_done   one-cycle pulse on clean frame completion
//   o_abort        one-cycle pulse when a collision aborts the frame
//
// Build option
//   DHT_CSUM_ERR_INJ_EN  adds i_csum_err; when it is latched high together
//                        with the payload, the checksum byte goes out inverted.
// ----------------------------------------------------------------------------
module dht_sensor_responder #(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int START_MIN_US  = 18000,
   parameter int RESP_DELAY_US = 30
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_bus,
   output logic       o_bus_oe,
   input  logic [7:0] i_humid_int,
   input  logic [7:0] i_humid_dec,
   input  logic [7:0] i_temp_int,
   input  logic [7:0] i_temp_dec,
`ifdef DHT_CSUM_ERR_INJ_EN
   input  logic       i_csum_err,
`endif
   output logic       o_busy,
   output logic       o_frame_done,
   output logic       o_abort
);

   // state      | meaning
   // -----------+---------------------------------------------------------
   // IDLE       | bus released, waiting for the host to pull low
   // HOST_LOW   | host holding the bus low, measuring the pulse width
   // HOST_REL   | host released after a valid start, response gap
   // RESP_LOW   | preamble low, 80 us
   // RESP_HIGH  | preamble release, 80 us (collision monitored)
   // BIT_LOW    | bit lead-in low, 50 us
   // BIT_HIGH   | bit release, 26 us (0) or 70 us (1) (collision monitored)
   // END_LOW    | closing low, 50 us, then frame done
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_HOST_LOW  = 3'd1;
   localparam logic [2:0] S_HOST_REL  = 3'd2;
   localparam logic [2:0] S_RESP_LOW  = 3'd3;
   localparam logic [2:0] S_RESP_HIGH = 3'd4;
   localparam logic [2:0] S_BIT_LOW   = 3'd5;
   localparam logic [2:0] S_BIT_HIGH  = 3'd6;
   localparam logic [2:0] S_END_LOW   = 3'd7;

   localparam int          TICK_DIV   = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
   localparam logic [15:0] PRESC_LOAD = 16'(TICK_DIV - 1);
   localparam logic [15:0] START_MIN  = 16'(START_MIN_US);
   localparam logic [15:0] RESP_DELAY = 16'(RESP_DELAY_US);
   localparam logic [15:0] T_RESP     = 16'd80;
   localparam logic [15:0] T_BIT_LOW  = 16'd50;
   localparam logic [15:0] T_ZERO     = 16'd26;
   localparam logic [15:0] T_ONE      = 16'd70;
   localparam logic [15:0] T_END      = 16'd50;
   // release phases ignore the bus for the first 2 us: sync latency plus
   // the pull-up rise after our own low
   localparam logic [15:0] T_MASK     = 16'd2;
   localparam logic [5:0]  LAST_BIT   = 6'd39;

   logic        bus_m;
   logic        bus_s;
   logic [15:0] presc;
   logic        tick;
   logic [15:0] us_cnt;
   logic [2:0]  state;
   logic [2:0]  state_nx;
   logic [15:0] phase_len;
   logic        phase_end;
   logic        in_high;
   logic        low_seen;
   logic        collide;
   logic [39:0] frame_sr;
   logic [5:0]  bit_idx;
   logic [7:0]  csum;
   logic [7:0]  csum_tx;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         bus_m <= 1'b1;
         bus_s <= 1'b1;
      end else begin
         bus_m <= i_bus;
         bus_s <= bus_m;
      end
   end

   // free-running down-counter, tick on terminal count
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         presc <= 16'd0;
      end else if (presc == 16'd0) begin
         presc <= PRESC_LOAD;
      end else begin
         presc <= presc - 16'd1;
      end
   end

   assign tick = (presc == 16'd0);

   assign csum = i_humid_int + i_humid_dec + i_temp_int + i_temp_dec;

`ifdef DHT_CSUM_ERR_INJ_EN
   assign csum_tx = csum ^ {8{i_csum_err}};
`else
   assign csum_tx = csum;
`endif

   always_comb begin
      phase_len = T_END;
      case (state)
         S_HOST_REL:              phase_len = RESP_DELAY;
         S_RESP_LOW, S_RESP_HIGH: phase_len = T_RESP;
         S_BIT_LOW:               phase_len = T_BIT_LOW;
         S_BIT_HIGH:              phase_len = frame_sr[39] ? T_ONE : T_ZERO;
         default:                 phase_len = T_END;
      endcase
   end

   // a phase ends on the tick that brings us_cnt up to its length
   assign phase_end = tick && (us_cnt == phase_len - 16'd1);

   assign in_high = (state == S_RESP_HIGH) || (state == S_BIT_HIGH);

   // second consecutive low tick inside the monitored window
   assign collide = tick && in_high && (us_cnt >= T_MASK) && !bus_s && low_seen;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (!bus_s) state_nx = S_HOST_LOW;
         end
         S_HOST_LOW: begin
            if (bus_s) state_nx = (us_cnt >= START_MIN) ? S_HOST_REL : S_IDLE;
         end
         S_HOST_REL: begin
            if (phase_end) state_nx = S_RESP_LOW;
         end
         S_RESP_LOW: begin
            if (phase_end) state_nx = S_RESP_HIGH;
         end
         S_RESP_HIGH: begin
            if (collide)        state_nx = S_HOST_LOW;
            else if (phase_end) state_nx = S_BIT_LOW;
         end
         S_BIT_LOW: begin
            if (phase_end) state_nx = S_BIT_HIGH;
         end
         S_BIT_HIGH: begin
            if (collide)        state_nx = S_HOST_LOW;
            else if (phase_end) state_nx = (bit_idx == LAST_BIT) ? S_END_LOW : S_BIT_LOW;
         end
         S_END_LOW: begin
            if (phase_end) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state        <= S_IDLE;
         us_cnt       <= 16'd0;
         low_seen     <= 1'b0;
         frame_sr     <= 40'd0;
         bit_idx      <= 6'd0;
         o_bus_oe     <= 1'b0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_abort      <= 1'b0;
      end else begin
         state <= state_nx;

         if (state_nx != state) begin
            us_cnt   <= 16'd0;
            low_seen <= 1'b0;
         end else begin
            // saturate so a very long host low cannot wrap below START_MIN
            if (tick && (us_cnt != 16'hFFFF)) us_cnt <= us_cnt + 16'd1;
            if (tick && in_high && (us_cnt >= T_MASK)) low_seen <= !bus_s;
         end

         if ((state == S_HOST_REL) && (state_nx == S_RESP_LOW)) begin
            frame_sr <= {i_humid_int, i_humid_dec, i_temp_int, i_temp_dec, csum_tx};
            bit_idx  <= 6'd0;
         end else if ((state == S_BIT_HIGH) && (state_nx == S_BIT_LOW)) begin
            frame_sr <= {frame_sr[38:0], 1'b0};
            bit_idx  <= bit_idx + 6'd1;
         end else if ((state_nx == S_IDLE) || (state_nx == S_HOST_LOW)) begin
            bit_idx  <= 6'd0;
         end

         // outputs follow the next state so they switch with the state register
         o_bus_oe     <= (state_nx == S_RESP_LOW) || (state_nx == S_BIT_LOW) ||
                         (state_nx == S_END_LOW);
         o_busy       <= !((state_nx == S_IDLE) || (state_nx == S_HOST_LOW));
         o_frame_done <= (state == S_END_LOW) && (state_nx == S_IDLE);
         o_abort      <= collide;
      end
   end

endmodule

// File: tb/tb_dht_sensor_responder.sv
`timescale 1ns/1ps
module tb_dht_sensor_responder;

   // 2 MHz clock keeps the run short: 1 us = 2 clocks
   localparam int CLK_HZ    = 2_000_000;
   localparam int CPU       = 2;
   localparam int START_MIN = 100;
   localparam int RESP_DLY  = 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       host_oe;
   logic       bus;
   logic       bus_oe;
   logic       busy;
   logic       frame_done;
   logic       abort_p;
   logic [7:0] hi, hd, ti, td;
`ifdef DHT_CSUM_ERR_INJ_EN
   logic       csum_err;
`endif

   always #5 clk = ~clk;

   // wired-AND open-drain bus with pull-up
   assign bus = ~(host_oe | bus_oe);

   dht_sensor_responder #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .START_MIN_US (START_MIN),
      .RESP_DELAY_US(RESP_DLY)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_bus       (bus),
      .o_bus_oe    (bus_oe),
      .i_humid_int (hi),
      .i_humid_dec (hd),
      .i_temp_int  (ti),
      .i_temp_dec  (td),
`ifdef DHT_CSUM_ERR_INJ_EN
      .i_csum_err  (csum_err),
`endif
      .o_busy      (busy),
      .o_frame_done(frame_done),
      .o_abort     (abort_p)
   );

   typedef struct {
      bit          is_abort;
      logic [39:0] bytes;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- monitor: decodes the responder's waveform ----------------
   int          m_run  = 0;
   int          m_lows = 0;
   int          m_werr = 0;
   logic        m_prev = 1'b0;
   logic [39:0] m_bits = '0;

   initial begin : monitor
      exp_t e;
      int   nom;
      logic b;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            m_run = 0; m_lows = 0; m_werr = 0; m_prev = 1'b0; m_bits = '0;
         end else begin
            if (bus_oe !== m_prev) begin
               if (m_prev) begin
                  m_lows++;
                  nom = (m_lows == 1) ? 80 : 50;
                  if (m_run < CPU*nom-2 || m_run > CPU*nom+1) m_werr++;
               end else if (m_lows >= 1) begin
                  if (m_lows == 1) begin
                     nom = 80;
                  end else begin
                     b      = (m_run > CPU*48);
                     m_bits = {m_bits[38:0], b};
                     nom    = b ? 70 : 26;
                  end
                  if (m_run < CPU*nom-2 || m_run > CPU*nom+1) m_werr++;
               end
               m_run = 1;
            end else begin
               m_run++;
            end
            m_prev = bus_oe;
            if (frame_done || abort_p) begin
               if (q.size() == 0) begin
                  chk(frame_done ? "unexpected_done" : "unexpected_abort", 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("event_kind_abort", 64'(abort_p), 64'(e.is_abort));
                  chk("event_not_both", 64'(frame_done & abort_p), 64'd0);
                  if (!e.is_abort) begin
                     chk("low_pulses", 64'(m_lows), 64'd42);
                     for (int i = 0; i < 5; i++)
                        chk($sformatf("byte%0d", i), 64'(m_bits[39-8*i -: 8]), 64'(e.bytes[39-8*i -: 8]));
                     chk("phase_widths_bad", 64'(m_werr), 64'd0);
                  end
               end
               m_run = 0; m_lows = 0; m_werr = 0; m_bits = '0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_us(input int us);
      repeat (us*CPU) @(negedge clk);
   endtask

   task automatic host_start(input int us);
      @(negedge clk);
      host_oe = 1'b1;
      wait_us(us);
      host_oe = 1'b0;
   endtask

   task automatic push_frame(input logic [39:0] b);
      exp_t e;
      e.is_abort = 1'b0;
      e.bytes    = b;
      q.push_back(e);
   endtask

   task automatic push_abort();
      exp_t e;
      e.is_abort = 1'b1;
      e.bytes    = '0;
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(q.size()), 64'd0);
   endtask

   task automatic wait_oe_edges(input int k, input bit rising, output bit ok, output int cyc);
      int   seen = 0;
      logic p    = bus_oe;
      cyc = 0;
      while (seen < k && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         if (rising ? (bus_oe && !p) : (!bus_oe && p)) seen++;
         p = bus_oe;
      end
      ok = (seen == k);
   endtask

   task automatic quiet(input int us, output bit act);
      act = 1'b0;
      repeat (us*CPU) begin
         @(negedge clk);
         if (bus_oe || busy || frame_done || abort_p) act = 1'b1;
      end
   endtask

   task automatic set_payload(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
      hi = a; hd = b; ti = c; td = d;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      bit ok, a1, a2;
      int cyc;
      rst_n   = 1'b0;
      host_oe = 1'b0;
      set_payload(8'd0, 8'd0, 8'd0, 8'd0);
`ifdef DHT_CSUM_ERR_INJ_EN
      csum_err = 1'b0;
`endif
      repeat (5) @(negedge clk);
      chk("rst_oe",    64'(bus_oe),     64'd0);
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_done",  64'(frame_done), 64'd0);
      chk("rst_abort", 64'(abort_p),    64'd0);
      rst_n = 1'b1;
      quiet(1000, a1);
      chk("idle_after_reset_activity", 64'(a1), 64'd0);

      // frame 55/0/24/3
      set_payload(8'd55, 8'd0, 8'd24, 8'd3);
      push_frame(40'h37_00_18_03_52);
      host_start(120);
      wait_oe_edges(1, 1'b1, ok, cyc);
      chk("resp_start_seen", 64'(ok), 64'd1);
      chk("resp_delay_in_window", 64'(cyc >= 58 && cyc <= 68), 64'd1);
      chk("busy_in_frame", 64'(busy), 64'd1);
      drain();
      wait_us(20);
      chk("busy_after_frame", 64'(busy), 64'd0);

      // short host low: glitch reject
      host_oe = 1'b1;
      quiet(40, a1);
      host_oe = 1'b0;
      quiet(300, a2);
      chk("glitch_activity", 64'(a1 | a2), 64'd0);

      // 200/100/200/100, payload changed after latch must not leak in
      set_payload(8'd200, 8'd100, 8'd200, 8'd100);
      push_frame(40'hC8_64_C8_64_58);
      host_start(120);
      wait_oe_edges(1, 1'b1, ok, cyc);
      chk("resp_start_seen_b", 64'(ok), 64'd1);
      set_payload(8'h11, 8'h22, 8'h33, 8'h44);
      drain();

      // collision 5 us into bit 10 high, then a clean restart
      set_payload(8'd55, 8'd0, 8'd24, 8'd3);
      push_abort();
      host_start(120);
      wait_oe_edges(12, 1'b0, ok, cyc);
      chk("bit10_high_seen", 64'(ok), 64'd1);
      wait_us(5);
      host_oe = 1'b1;
      wait_us(5);
      host_oe = 1'b0;
      drain();
      wait_us(20);
      chk("abort_oe_released", 64'(bus_oe), 64'd0);
      chk("abort_busy_low",    64'(busy),   64'd0);
      push_frame(40'h37_00_18_03_52);
      host_start(120);
      drain();
      wait_us(20);

      // reset during bit 0 low
      host_start(120);
      wait_oe_edges(2, 1'b1, ok, cyc);
      chk("bit0_low_seen", 64'(ok), 64'd1);
      wait_us(10);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_oe",   64'(bus_oe), 64'd0);
      chk("midreset_busy", 64'(busy),   64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      quiet(200, a1);
      chk("after_midreset_activity", 64'(a1), 64'd0);

      // all ones
      set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      push_frame(40'hFF_FF_FF_FF_FC);
      host_start(120);
      drain();
      wait_us(20);

`ifdef DHT_CSUM_ERR_INJ_EN
      set_payload(8'd55, 8'd0, 8'd24, 8'd3);
      csum_err = 1'b1;
      push_frame(40'h37_00_18_03_AD);
      host_start(120);
      wait_oe_edges(1, 1'b1, ok, cyc);
      csum_err = 1'b0;
      drain();
      wait_us(20);
`endif

      wait_us(100);
      chk("final_queue", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #(950_000);
      $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
